// File: rtl/adc_scan_pkg.sv
// Shared types and default constants for the multi-channel ADC0808 scanner.
// Holds the scan FSM state enum, default timing constants and MAX_CH.
package adc_scan_pkg;

    localparam int MAX_CH          = 8;
    localparam int DEF_CLK_DIV     = 100;
    localparam int DEF_PULSE_CYC   = 50;
    localparam int DEF_OE_CYC      = 30;
    localparam int DEF_TIMEOUT_CYC = 20000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ALE,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_READ,
        S_STORE
    } state_t;

endpackage

// File: rtl/adc_clk_gen.sv
// Free-running converter clock divider: adc_clk toggles every CLK_DIV clocks.
// Ports: clk (system clock), reset (async, active-low), adc_clk (divided clock).
import adc_scan_pkg::*;

module adc_clk_gen #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic adc_clk
);

    localparam int CW = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            adc_clk <= 1'b0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt     <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc0808_scanner.sv
// Round-robin ADC0808 scanner: sequences addr/ale/start/oe, stores one result
// per channel, flags EOC timeouts. Ports: CLK100MHZ, reset (async, active-low),
// enable, eoc, data_in | adc_clk, ale, start, oe, addr, sample_valid/ch/data,
// rd_ch -> rd_data (registered), err_flags (sticky), scan_done.
// Option: define ADC_SCAN_AVG_EN to store an exponential average per channel.
import adc_scan_pkg::*;

module adc0808_scanner #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int OE_CYC      = DEF_OE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`ifdef ADC_SCAN_AVG_EN
    ,
    parameter int AVG_SHIFT   = 3
`endif
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              enable,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    output logic              adc_clk,
    output logic              ale,
    output logic              start,
    output logic              oe,
    output logic [2:0]        addr,
    output logic              sample_valid,
    output logic [2:0]        sample_ch,
    output logic [DATA_W-1:0] sample_data,
    input  logic [2:0]        rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0] err_flags,
    output logic              scan_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + PULSE_CYC + OE_CYC + 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        eoc_ff;
    logic              eoc_sync;
    logic [2:0]        ch;
    logic [2:0]        ch_nx;
    logic              last_ch;
    logic              pulse_end;
    logic              oe_end;
    logic              tmo;
    logic              capture;
    logic              timeout;
    logic              advance;
    logic [DATA_W-1:0] store_val;
    logic [DATA_W-1:0] mem [MAX_CH];
    logic [MAX_CH-1:0] err_q;

    adc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .adc_clk (adc_clk)
    );

    assign eoc_sync  = eoc_ff[1];
    assign last_ch   = (ch == 3'(NUM_CH - 1));
    assign ch_nx     = last_ch ? 3'd0 : ch + 3'd1;
    assign pulse_end = (cnt == CNT_W'(PULSE_CYC - 1));
    assign oe_end    = (cnt == CNT_W'(OE_CYC - 1));
    assign tmo       = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign addr      = ch;
    assign err_flags = err_q[NUM_CH-1:0];

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // An EOC edge seen in the same cycle as the timeout wins.
    always_comb begin
        state_nx = state;
        ale      = 1'b0;
        start    = 1'b0;
        oe       = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nx = S_SETUP;
            end
            S_SETUP: begin
                if (pulse_end) state_nx = S_ALE;
            end
            S_ALE: begin
                ale = 1'b1;
                if (pulse_end) state_nx = S_START;
            end
            S_START: begin
                start = 1'b1;
                if (pulse_end) state_nx = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!eoc_sync) begin
                    state_nx = S_WAIT_HI;
                end else if (tmo) begin
                    timeout  = 1'b1;
                    state_nx = enable ? S_SETUP : S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (eoc_sync) begin
                    state_nx = S_READ;
                end else if (tmo) begin
                    timeout  = 1'b1;
                    state_nx = enable ? S_SETUP : S_IDLE;
                end
            end
            S_READ: begin
                oe = 1'b1;
                if (oe_end) begin
                    capture  = 1'b1;
                    state_nx = S_STORE;
                end
            end
            S_STORE: begin
                state_nx = enable ? S_SETUP : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The pointer always moves on after a channel, so a paused scan
    // resumes at the following channel.
    assign advance = (state == S_STORE) || timeout;

`ifdef ADC_SCAN_AVG_EN
    logic [MAX_CH-1:0]      primed;
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] step;

    always_comb begin
        diff      = $signed({1'b0, data_in}) - $signed({1'b0, mem[ch]});
        step      = diff >>> AVG_SHIFT;
        store_val = data_in;
        if (primed[ch]) begin
            store_val = DATA_W'($signed({1'b0, mem[ch]}) + step);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset)       primed     <= '0;
        else if (capture) primed[ch] <= 1'b1;
    end
`else
    assign store_val = data_in;
`endif

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            eoc_ff       <= 2'b00;
            cnt          <= '0;
            ch           <= 3'd0;
            err_q        <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
        end else begin
            eoc_ff       <= {eoc_ff[0], eoc};
            sample_valid <= capture;
            scan_done    <= capture && last_ch;
            if (state_nx != state || state == S_IDLE) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;
            if (capture) begin
                sample_ch   <= ch;
                sample_data <= store_val;
                err_q[ch]   <= 1'b0;
            end
            if (timeout) err_q[ch] <= 1'b1;
            if (advance) ch <= ch_nx;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_CH; i++) mem[i] <= '0;
        end else if (capture) begin
            mem[ch] <= store_val;
        end
    end

    // Registered read: a same-cycle store is seen one clock later.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if ({1'b0, rd_ch} < 4'(NUM_CH)) begin
            rd_data <= mem[rd_ch];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_adc0808_scanner.sv
// Self-checking bench for adc0808_scanner with a behavioural ADC0808 model
// and a per-channel expected-storage model.
module tb_adc0808_scanner;

    localparam int NCH  = 4;
    localparam int CDIV = 4;
    localparam int PCYC = 3;
    localparam int OCYC = 2;
    localparam int TCYC = 200;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic       eoc     = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [2:0] rd_ch   = 3'd0;
    logic       adc_clk, ale, start, oe;
    logic [2:0] addr;
    logic       sample_valid;
    logic [2:0] sample_ch;
    logic [7:0] sample_data;
    logic [7:0] rd_data;
    logic [NCH-1:0] err_flags;
    logic       scan_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] adc_val [8];
    logic [7:0] exp_mem [NCH];
    bit         exp_primed [NCH];
    logic [2:0] dead_ch = 3'd7;

    logic       start_d = 1'b0;
    logic       busy    = 1'b0;
    logic       dead    = 1'b0;
    logic [2:0] lat_addr = 3'd0;
    int         conv_cnt = 0;
    int         dly      = 20;

    adc0808_scanner #(
        .NUM_CH      (NCH),
        .DATA_W      (8),
        .CLK_DIV     (CDIV),
        .PULSE_CYC   (PCYC),
        .OE_CYC      (OCYC),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (rst_n),
        .enable       (enable),
        .eoc          (eoc),
        .data_in      (data_in),
        .adc_clk      (adc_clk),
        .ale          (ale),
        .start        (start),
        .oe           (oe),
        .addr         (addr),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .rd_ch        (rd_ch),
        .rd_data      (rd_data),
        .err_flags    (err_flags),
        .scan_done    (scan_done)
    );

    always #5 clk = ~clk;

    // ADC0808 model: latches addr on ale, EOC drops shortly after start and
    // rises 15..60 clocks later with that channel's value on the bus.
    // A "dead" channel leaves EOC low.
    always @(posedge clk) begin
        start_d <= start;
        if (ale) lat_addr <= addr;
        if (start && !start_d) begin
            busy     <= 1'b1;
            conv_cnt <= 0;
            dly      <= int'($urandom_range(60, 15));
            dead     <= (lat_addr == dead_ch);
        end else if (busy) begin
            conv_cnt <= conv_cnt + 1;
            if (conv_cnt == 2) eoc <= 1'b0;
            if (conv_cnt == dly) begin
                busy <= 1'b0;
                if (!dead) begin
                    eoc     <= 1'b1;
                    data_in <= adc_val[lat_addr];
                end
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            exp_mem[i]    = 8'h00;
            exp_primed[i] = 1'b0;
        end
    endfunction

    function automatic logic [7:0] model_store(int c, logic [7:0] v);
        int d;
        int st;
`ifdef ADC_SCAN_AVG_EN
        if (!exp_primed[c]) begin
            exp_mem[c] = v;
        end else begin
            d  = int'(v) - int'(exp_mem[c]);
            st = (d >= 0) ? d / 8 : -((-d + 7) / 8);
            exp_mem[c] = 8'((int'(exp_mem[c]) + st) & 255);
        end
`else
        d  = 0;
        st = d;
        exp_mem[c] = v;
`endif
        exp_primed[c] = 1'b1;
        return exp_mem[c];
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        rd_ch  = 3'd0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        dead_ch = 3'd7;
        model_reset();
        @(negedge clk);
    endtask

    task automatic wait_sample(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        rd_ch  = 3'd0;
        repeat (5) @(negedge clk);
        n_checks++; if (ale !== 1'b0) begin n_fail++; $display("FAIL rst_ale: got %b want 0", ale); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", start); end
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", oe); end
        n_checks++; if (addr !== 3'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", addr); end
        n_checks++; if (adc_clk !== 1'b0) begin n_fail++; $display("FAIL rst_adc_clk: got %b want 0", adc_clk); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
        n_checks++; if (sample_data !== 8'h00) begin n_fail++; $display("FAIL rst_sdata: got %h want 00", sample_data); end
        n_checks++; if (sample_ch !== 3'd0) begin n_fail++; $display("FAIL rst_sch: got %0d want 0", sample_ch); end
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL rst_err: got %b want 0000", err_flags); end
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", scan_done); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd: got %h want 00", rd_data); end
        enable = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_adc_clk();
        int   r1 = -1;
        int   r2 = -1;
        int   f1 = -1;
        logic prev;
        prev = adc_clk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (adc_clk && !prev) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (!adc_clk && prev && r1 >= 0 && f1 < 0) f1 = i;
            prev = adc_clk;
        end
        n_checks++; if (r2 - r1 != 2 * CDIV || r1 < 0) begin n_fail++; $display("FAIL adc_clk_period: got %0d want %0d", r2 - r1, 2 * CDIV); end
        n_checks++; if (f1 - r1 != CDIV || r1 < 0) begin n_fail++; $display("FAIL adc_clk_high: got %0d want %0d", f1 - r1, CDIV); end
    endtask

    task automatic test_strobes();
        int w;
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 8'h5A;
        enable = 1'b1;
        w = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            w++;
            if (ale) break;
        end
        n_checks++; if (w != PCYC + 1) begin n_fail++; $display("FAIL setup_len: got %0d want %0d", w, PCYC + 1); end
        n_checks++; if (addr !== 3'd0) begin n_fail++; $display("FAIL ale_addr: got %0d want 0", addr); end
        w = 0;
        while (ale && w < 50) begin @(negedge clk); w++; end
        n_checks++; if (w != PCYC) begin n_fail++; $display("FAIL ale_width: got %0d want %0d", w, PCYC); end
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL ale_to_start: got %b want 1", start); end
        w = 0;
        while (start && w < 50) begin @(negedge clk); w++; end
        n_checks++; if (w != PCYC) begin n_fail++; $display("FAIL start_width: got %0d want %0d", w, PCYC); end
        for (int i = 0; i < 500; i++) begin
            if (oe) break;
            @(negedge clk);
        end
        w = 0;
        while (oe && w < 50) begin @(negedge clk); w++; end
        n_checks++; if (w != OCYC) begin n_fail++; $display("FAIL oe_width: got %0d want %0d", w, OCYC); end
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL oe_to_sample: got %b want 1", sample_valid); end
        n_checks++; if (sample_data !== 8'h5A) begin n_fail++; $display("FAIL first_data: got %h want 5a", sample_data); end
        enable = 1'b0;
    endtask

    task automatic test_scan();
        bit         ok;
        int         c;
        logic [7:0] old;
        logic [7:0] e;
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 8'(16 * k);
        enable = 1'b1;
        for (int n = 0; n < 3 * NCH; n++) begin
            c = n % NCH;
            if (n == 2 * NCH) begin
                for (int k = 0; k < NCH; k++) adc_val[k] = 8'($urandom_range(255, 0));
                adc_val[0] = adc_val[0] | 8'h01;
                rd_ch = 3'd0;
            end
            wait_sample(ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL scan_wait: got timeout want sample n=%0d", n); end
            n_checks++; if (sample_ch !== 3'(c)) begin n_fail++; $display("FAIL scan_ch: got %0d want %0d", sample_ch, c); end
            old = exp_mem[c];
            e   = model_store(c, adc_val[c]);
            n_checks++; if (sample_data !== e) begin n_fail++; $display("FAIL scan_data ch%0d: got %h want %h", c, sample_data, e); end
            n_checks++; if (scan_done !== (c == NCH - 1)) begin n_fail++; $display("FAIL scan_done ch%0d: got %b want %b", c, scan_done, c == NCH - 1); end
            if (n == 2 * NCH) begin
                n_checks++; if (rd_data !== old) begin n_fail++; $display("FAIL rd_same_cycle: got %h want %h", rd_data, old); end
            end
            if (n == 3 * NCH - 1) enable = 1'b0;
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b want 0", sample_valid); end
            n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", scan_done); end
            if (n == 2 * NCH) begin
                n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL rd_next_cycle: got %h want %h", rd_data, e); end
            end
        end
    endtask

    task automatic test_rd_port();
        for (int k = 0; k < 8; k++) begin
            rd_ch = 3'(k);
            @(negedge clk);
            if (k < NCH) begin
                n_checks++; if (rd_data !== exp_mem[k]) begin n_fail++; $display("FAIL rd_ch%0d: got %h want %h", k, rd_data, exp_mem[k]); end
            end else begin
                n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_oob%0d: got %h want 00", k, rd_data); end
            end
        end
    endtask

    task automatic test_timeout();
        bit         ok;
        logic [7:0] e;
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 8'($urandom_range(255, 0)) | 8'h01;
        enable = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            wait_sample(ok);
            n_checks++; if (ok !== 1'b1 || sample_ch !== 3'(c)) begin n_fail++; $display("FAIL to_pass1 ch%0d: got ok=%b ch=%0d", c, ok, sample_ch); end
            e = model_store(c, adc_val[c]);
        end
        dead_ch    = 3'd2;
        adc_val[2] = ~exp_mem[2];
        for (int c = 0; c < 2; c++) begin
            wait_sample(ok);
            n_checks++; if (ok !== 1'b1 || sample_ch !== 3'(c)) begin n_fail++; $display("FAIL to_pass2 ch%0d: got ok=%b ch=%0d", c, ok, sample_ch); end
            e = model_store(c, adc_val[c]);
        end
        rd_ch = 3'd2;
        wait_sample(ok);
        n_checks++; if (ok !== 1'b1 || sample_ch !== 3'd3) begin n_fail++; $display("FAIL to_skip: got ok=%b ch=%0d want ch 3", ok, sample_ch); end
        n_checks++; if (err_flags !== 4'b0100) begin n_fail++; $display("FAIL to_flag: got %b want 0100", err_flags); end
        n_checks++; if (rd_data !== exp_mem[2]) begin n_fail++; $display("FAIL to_keep: got %h want %h", rd_data, exp_mem[2]); end
        e = model_store(3, adc_val[3]);
        n_checks++; if (sample_data !== e) begin n_fail++; $display("FAIL to_ch3: got %h want %h", sample_data, e); end
        dead_ch = 3'd7;
        for (int c = 0; c < 3; c++) begin
            wait_sample(ok);
            n_checks++; if (ok !== 1'b1 || sample_ch !== 3'(c)) begin n_fail++; $display("FAIL to_pass3 ch%0d: got ok=%b ch=%0d", c, ok, sample_ch); end
            e = model_store(c, adc_val[c]);
            n_checks++; if (sample_data !== e) begin n_fail++; $display("FAIL to_pass3_data ch%0d: got %h want %h", c, sample_data, e); end
            if (c == 1) begin
                n_checks++; if (err_flags !== 4'b0100) begin n_fail++; $display("FAIL to_sticky: got %b want 0100", err_flags); end
            end
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL to_clear: got %b want 0000", err_flags); end
    endtask

    task automatic test_enable_drop();
        bit         ok;
        logic [7:0] e;
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 8'($urandom_range(255, 0));
        enable = 1'b1;
        wait_sample(ok);
        e = model_store(0, adc_val[0]);
        n_checks++; if (ok !== 1'b1 || sample_ch !== 3'd0) begin n_fail++; $display("FAIL en_ch0: got ok=%b ch=%0d", ok, sample_ch); end
        for (int i = 0; i < 500; i++) begin
            if (!eoc) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        enable = 1'b0;
        wait_sample(ok);
        e = model_store(1, adc_val[1]);
        n_checks++; if (ok !== 1'b1 || sample_ch !== 3'd1) begin n_fail++; $display("FAIL en_ch1: got ok=%b ch=%0d want 1", ok, sample_ch); end
        n_checks++; if (sample_data !== e) begin n_fail++; $display("FAIL en_ch1_data: got %h want %h", sample_data, e); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ale || start || oe || sample_valid) ok = 1'b1;
        end
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL en_idle: got activity want none"); end
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ale) break;
        end
        n_checks++; if (ale !== 1'b1 || addr !== 3'd2) begin n_fail++; $display("FAIL en_resume_addr: got ale=%b addr=%0d want addr 2", ale, addr); end
        wait_sample(ok);
        n_checks++; if (ok !== 1'b1 || sample_ch !== 3'd2) begin n_fail++; $display("FAIL en_resume_ch: got ok=%b ch=%0d want 2", ok, sample_ch); end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit         ok;
        logic [7:0] e;
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 8'($urandom_range(255, 0)) | 8'h01;
        enable = 1'b1;
        wait_sample(ok);
        e = model_store(0, adc_val[0]);
        @(negedge clk);
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL rm_before: got %h want %h", rd_data, e); end
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (oe) begin ok = 1'b1; break; end
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ok !== 1'b1 || oe !== 1'b0) begin n_fail++; $display("FAIL rm_oe: got ok=%b oe=%b want oe 0", ok, oe); end
        n_checks++; if (ale !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL rm_strobes: got ale=%b start=%b want 0", ale, start); end
        n_checks++; if (addr !== 3'd0) begin n_fail++; $display("FAIL rm_addr: got %0d want 0", addr); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rm_rd: got %h want 00", rd_data); end
        n_checks++; if (sample_data !== 8'h00) begin n_fail++; $display("FAIL rm_sdata: got %h want 00", sample_data); end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rm_storage: got %h want 00", rd_data); end
    endtask

`ifdef ADC_SCAN_AVG_EN
    task automatic test_avg();
        bit ok;
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 8'h11;
        adc_val[0] = 8'h80;
        enable = 1'b1;
        wait_sample(ok);
        n_checks++; if (ok !== 1'b1 || sample_data !== 8'h80) begin n_fail++; $display("FAIL avg_first: got %h want 80", sample_data); end
        adc_val[0] = 8'h00;
        for (int n = 0; n < NCH; n++) wait_sample(ok);
        enable = 1'b0;
        n_checks++; if (ok !== 1'b1 || sample_ch !== 3'd0 || sample_data !== 8'h70) begin n_fail++; $display("FAIL avg_second: got ch=%0d %h want ch 0 70", sample_ch, sample_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_adc_clk();
        test_strobes();
        test_scan();
        test_rd_port();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
`ifdef ADC_SCAN_AVG_EN
        test_avg();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/adc0808_scanner.md
# adc0808_scanner

Parametrised multi-channel successor to the single-channel ADC0808 interface. Round-robin scans `NUM_CH` analog inputs and generates ADC clock, `ale`/`start`/`oe` sequencing with programmable pulse widths. Stores one result per channel, flags EOC timeouts, and exposes a streaming sample port plus a random-access read port. Sits between the ADC pins (JB header) and display/BCD logic in the ADC top level.

## Interface
- `NUM_CH`, 8: channels scanned, 1..8; `addr` counts 0..NUM_CH-1.
- `DATA_W`, 8: converter data width (8 for ADC0808/0809).
- `CLK_DIV`, 100: half-period of `adc_clk` in system clocks (100 MHz / 200 = 500 kHz).
- `PULSE_CYC`, 50: width of `ale`, `start` and address setup, in clocks (500 ns).
- `OE_CYC`, 30: clocks `oe` is held before capture (data settle).
- `TIMEOUT_CYC`, 20000: maximum clocks waiting for each EOC edge.
- `AVG_SHIFT`, 3: averaging weight 1/2^AVG_SHIFT (used only with `ADC_SCAN_AVG_EN`).

- `CLK100MHZ`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scanning runs while high.
- `eoc`  in  1  ADC end-of-conversion; asynchronous, 2-flop synchronised internally.
- `data_in`  in  DATA_W  ADC data bus.
- `adc_clk`  out  1  converter clock.
- `ale`, `start`, `oe`  out  1 each  ADC control strobes.
- `addr`  out  3  channel select.
- `sample_valid`  out  1  one-cycle strobe, new sample stored.
- `sample_ch`  out  3  channel of current sample.
- `sample_data`  out  DATA_W  stored value of that sample.
- `rd_ch`  in  3  read-port channel select.
- `rd_data`  out  DATA_W  registered stored value of `rd_ch`.
- `err_flags`  out  NUM_CH  sticky per-channel timeout flags.
- `scan_done`  out  1  one-cycle pulse after the last channel of a pass.

## Operation
- FSM: IDLE -> SETUP (addr driven, PULSE_CYC) -> ALE (PULSE_CYC) -> START (PULSE_CYC) -> WAIT_LO (eoc_sync low) -> WAIT_HI (eoc_sync high) -> READ (oe high, OE_CYC) -> STORE (1 cycle) -> SETUP for next channel, or IDLE.
- Leaving IDLE requires `enable`=1. After STORE: if `enable`=0, go to IDLE; otherwise advance channel.
- Channel increments modulo NUM_CH. Wrap from NUM_CH-1 to 0 raises `scan_done` in the STORE cycle.
- `enable` falling mid-conversion: the current conversion completes and is stored, then the FSM enters IDLE. The channel pointer is kept, and the next enable resumes at the following channel.
- Timeout: a cycle counter is loaded on entry to WAIT_LO and WAIT_HI. On reaching TIMEOUT_CYC:
  - set `err_flags[ch]`;
  - do not store, so the previous value and `sample_valid` stay unchanged;
  - go to the next channel via SETUP.
- `err_flags[ch]` clears on the next successful store for that channel.
- `adc_clk` toggles every CLK_DIV clocks continuously while out of reset, independent of `enable`.
- `rd_ch` >= NUM_CH returns 0.

## Timing
- Reset values: all outputs 0, `addr` 0, `adc_clk` 0, storage 0, FSM IDLE, channel pointer 0.
- Reset asserted mid-operation clears everything immediately. The ADC is not waited on.
- `data_in` is sampled on the last READ cycle. `sample_valid`, `sample_ch` and `sample_data` are updated in STORE, visible the cycle after capture.
- `rd_data` latency: 1 clock after `rd_ch` changes. A store and a read of the same channel in the same cycle returns the old value, and the new value appears next cycle.
- `eoc` path latency: 2 clocks. Both edges are detected on the synchronised level.
- Nominal conversion: 3·PULSE_CYC + EOC time + OE_CYC + 1 clocks.

## Configuration
- `ADC_SCAN_AVG_EN` defined: each channel stores an exponential average, `avg <= avg + ((new - avg) >>> AVG_SHIFT)`.
  - Arithmetic is signed, DATA_W+1 bits; the result is truncated to DATA_W.
  - The first successful sample per channel after reset loads directly, tracked by a per-channel `primed` bit.
- `ADC_SCAN_AVG_EN` undefined: raw capture is stored, and no `primed` bits are synthesised.

## Structure
- Package `adc_scan_pkg` holds:
  - the FSM state enum;
  - default parameter constants (CLK_DIV, PULSE_CYC, OE_CYC, TIMEOUT_CYC);
  - a `MAX_CH` = 8 constant.
- Sub-module `adc_clk_gen`: divider producing `adc_clk` from CLK100MHZ/CLK_DIV, with async active-low reset.

## Test plan
- ADC model with EOC 100 µs after start, channel k returns 0x10·k, NUM_CH=4, `enable`=1 -> stored 0x00,0x10,0x20,0x30, `sample_ch` 0..3 in order, `scan_done` once per pass.
- Model never raises EOC on channel 2 -> `err_flags`=4'b0100 after TIMEOUT_CYC, channel 2 keeps its old value, scan continues to channel 3. Fix the model and let channel 2 convert successfully -> flag clears.
- `enable` dropped during WAIT_HI of channel 1 -> channel 1 stored, FSM idles. Re-enable -> next `addr`=2.
- Reset pulsed low during READ -> `oe`, `ale`, `start` and `addr` are 0 immediately, storage cleared, `rd_data`=0.
- `ADC_SCAN_AVG_EN`, AVG_SHIFT=3, channel 0 samples 0x80 then 0x00 -> stored 0x80, then 0x70.
- `rd_ch`=5 with NUM_CH=4 -> `rd_data`=0. `adc_clk` period measured = 2·CLK_DIV clocks.
